cpu_ctrl: RTL

CPU_CTRL -- requirements
Module: cpu_ctrl

---
 rtl/cpu_ctrl_if.sv | 23 ++
 rtl/cpu_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_if.sv
// Memory and ALU side-bus of the cpu_ctrl sequencer.
// master = controller side, slave = memory/ALU side.
interface cpu_ctrl_if;
    logic [7:0] mem_addr;
    logic       mem_re;
    logic [7:0] mem_rdata;
    logic [7:0] alu_accum;
    logic [7:0] alu_in;
    logic [3:0] alu_sel;
    logic [7:0] alu_result;
    logic       alu_z;
    logic       alu_c;

    modport master (
        output mem_addr, mem_re, alu_accum, alu_in, alu_sel,
        input  mem_rdata, alu_result, alu_z, alu_c
    );

    modport slave (
        input  mem_addr, mem_re, alu_accum, alu_in, alu_sel,
        output mem_rdata, alu_result, alu_z, alu_c
    );
endinterface

// File: rtl/cpu_ctrl.sv
// Multi-cycle 8-bit accumulator CPU sequencer: fetch/decode/execute FSM driving
// a synchronous memory and an external combinational ALU.
module cpu_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    cpu_ctrl_if.master bus,
    output logic [7:0] pc_out,
    output logic [7:0] acc_out,
    output logic       halted,
    output logic       illegal_op
);
    localparam int unsigned DW   = 8;
    localparam int unsigned OPW  = 4;
    localparam int unsigned NREG = 4;

    localparam logic [OPW-1:0] OP_ADD  = 4'h1;
    localparam logic [OPW-1:0] OP_SUB  = 4'h2;
    localparam logic [OPW-1:0] OP_NOR  = 4'h3;
    localparam logic [OPW-1:0] OP_MOVR = 4'h4;
    localparam logic [OPW-1:0] OP_MOVA = 4'h5;
    localparam logic [OPW-1:0] OP_LDI  = 4'h6;
    localparam logic [OPW-1:0] OP_JZ   = 4'h7;
    localparam logic [OPW-1:0] OP_JC   = 4'h8;
    localparam logic [OPW-1:0] OP_JMP  = 4'h9;
    localparam logic [OPW-1:0] OP_HALT = 4'hA;
    localparam logic [OPW-1:0] OP_SHL  = 4'hB;
    localparam logic [OPW-1:0] OP_SHR  = 4'hC;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, OPERAND, HALTED} state_t;

    state_t           state;
    logic [DW-1:0]    pc;
    logic [DW-1:0]    acc;
    logic [DW-1:0]    ir;
    logic [DW-1:0]    regs [NREG];
    logic             z;
    logic             c;
    logic [DW-1:0]    mem_addr_q;
    logic             mem_re_q;
    logic [OPW-1:0]   alu_sel_q;
    logic [DW-1:0]    alu_in_q;
    logic             halted_q;
    logic             illegal_q;

    logic [OPW-1:0]   ir_op;
    logic [1:0]       ir_rsel;
    logic [OPW-1:0]   rd_op;
    logic [1:0]       rd_rsel;
    logic [DW-1:0]    pc_inc;
    logic [DW-1:0]    operand_pc;
    logic             ir_unused;

    assign ir_op     = ir[7:4];
    assign ir_rsel   = ir[1:0];
    assign ir_unused = ^ir[3:2];
    assign rd_op     = bus.mem_rdata[7:4];
    assign rd_rsel   = bus.mem_rdata[1:0];
    assign pc_inc    = pc + DW'(1);

    function automatic logic is_alu(input logic [OPW-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NOR) ||
               (op == OP_MOVR) || (op == OP_SHL) || (op == OP_SHR);
    endfunction

    function automatic logic is_two_byte(input logic [OPW-1:0] op);
        return (op == OP_LDI) || (op == OP_JZ) || (op == OP_JC) || (op == OP_JMP);
    endfunction

    function automatic logic is_illegal(input logic [OPW-1:0] op);
        return op > OP_SHR;
    endfunction

    // PC after the operand byte: branch target or fall-through past the operand
    always_comb begin
        operand_pc = pc_inc;
        case (ir_op)
            OP_JMP:  operand_pc = bus.mem_rdata;
            OP_JZ:   if (z) operand_pc = bus.mem_rdata;
            OP_JC:   if (c) operand_pc = bus.mem_rdata;
            default: operand_pc = pc_inc;
        endcase
    end

    // Bus outputs are registered, so each state sets up the strobes of the next one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= '0;
            acc        <= '0;
            ir         <= '0;
            z          <= 1'b0;
            c          <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
            mem_addr_q <= '0;
            mem_re_q   <= 1'b0;
            alu_sel_q  <= '0;
            alu_in_q   <= '0;
            halted_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            mem_addr_q <= '0;
            mem_re_q   <= 1'b0;
            alu_sel_q  <= '0;
            alu_in_q   <= '0;
            illegal_q  <= 1'b0;
            case (state)
                IDLE: begin
                    state      <= FETCH;
                    mem_re_q   <= 1'b1;
                    mem_addr_q <= pc;
                end
                FETCH: state <= DECODE;
                DECODE: begin
                    state <= EXEC;
                    ir    <= bus.mem_rdata;
                    pc    <= pc_inc;
                    if (is_alu(rd_op)) begin
                        alu_sel_q <= rd_op;
                        alu_in_q  <= regs[rd_rsel];
                    end
                    if (is_two_byte(rd_op)) begin
                        mem_re_q   <= 1'b1;
                        mem_addr_q <= pc_inc;
                    end
                    if (is_illegal(rd_op)) illegal_q <= 1'b1;
                end
                EXEC: begin
                    if (is_two_byte(ir_op)) begin
                        state <= OPERAND;
                    end else if (ir_op == OP_HALT) begin
                        state    <= HALTED;
                        halted_q <= 1'b1;
                    end else begin
                        state      <= FETCH;
                        mem_re_q   <= 1'b1;
                        mem_addr_q <= pc;
                    end
                    if (is_alu(ir_op)) begin
                        acc <= bus.alu_result;
                        z   <= bus.alu_z;
                        c   <= bus.alu_c;
                    end
                    if (ir_op == OP_MOVA) regs[ir_rsel] <= acc;
                end
                OPERAND: begin
                    state      <= FETCH;
                    pc         <= operand_pc;
                    mem_re_q   <= 1'b1;
                    mem_addr_q <= operand_pc;
                    if (ir_op == OP_LDI) begin
                        acc <= bus.mem_rdata;
                        z   <= (bus.mem_rdata == '0);
                    end
                end
                HALTED:  state <= HALTED;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.alu_sel   = alu_sel_q;
    assign bus.alu_in    = alu_in_q;
    assign bus.alu_accum = acc;
    assign pc_out        = pc;
    assign acc_out       = acc;
    assign halted        = halted_q;
    assign illegal_op    = illegal_q;
endmodule
